// File: rtl/uns_acc_ctrl_if.sv
// uns_acc_ctrl_if: job, beat stream, accumulator and status signals of the accumulator sequencer
// Ports (all grouped here; clk/rst stay on the modules):
//   job:    i_start, i_op, i_len
//   beats:  i_valid, o_ready, i_data1, i_data2
//   accum:  o_acc_rst_n, o_acc_sel, o_acc_data1, o_acc_data2, i_acc_data, i_acc_carry
//   status: o_busy, o_done, o_result, o_ovf
// slave is the controller view, master is the job source plus accumulator view.
interface uns_acc_ctrl_if #(
    parameter int DW = 3,
    parameter int AW = 6,
    parameter int CW = 4
);
    logic          i_start;
    logic [1:0]    i_op;
    logic [CW-1:0] i_len;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data1;
    logic [DW-1:0] i_data2;
    logic          o_acc_rst_n;
    logic [1:0]    o_acc_sel;
    logic [DW-1:0] o_acc_data1;
    logic [DW-1:0] o_acc_data2;
    logic [AW-1:0] i_acc_data;
    logic          i_acc_carry;
    logic          o_busy;
    logic          o_done;
    logic [AW-1:0] o_result;
    logic          o_ovf;

    modport slave (
        input  i_start, i_op, i_len, i_valid, i_data1, i_data2, i_acc_data, i_acc_carry,
        output o_ready, o_acc_rst_n, o_acc_sel, o_acc_data1, o_acc_data2,
               o_busy, o_done, o_result, o_ovf
    );

    modport master (
        output i_start, i_op, i_len, i_valid, i_data1, i_data2, i_acc_data, i_acc_carry,
        input  o_ready, o_acc_rst_n, o_acc_sel, o_acc_data1, o_acc_data2,
               o_busy, o_done, o_result, o_ovf
    );
endinterface

// File: rtl/uns_acc_ctrl.sv
// uns_acc_ctrl: sequences one accumulator job (clear, stream beats, drain, capture sum/carry)
// Ports:
//   clk   rising-edge clock
//   i_rst asynchronous active-high reset
//   bus   uns_acc_ctrl_if.slave carrying job, beat handshake, accumulator and status signals
module uns_acc_ctrl #(
    parameter int         DW       = 3,
    parameter int         AW       = 6,
    parameter int         CW       = 4,
    parameter logic [1:0] HOLD_SEL = 2'b11
) (
    input logic           clk,
    input logic           i_rst,
    uns_acc_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, CAPTURE} state_t;

    state_t        state, state_nx;
    logic [1:0]    op_q;
    logic [CW-1:0] len_q;
    logic [CW-1:0] rem;
    logic          sticky;
    logic          accept;
    logic          acc_rst_n;
    logic [1:0]    acc_sel;
    logic [DW-1:0] acc_data1, acc_data2;
    logic          done;
    logic [AW-1:0] result;
    logic          ovf;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = (state == RUN) && bus.i_valid;
        case (state)
            IDLE:    state_nx = bus.i_start ? CLEAR : IDLE;
            CLEAR:   state_nx = (len_q == '0) ? DRAIN : RUN;
            RUN:     state_nx = (accept && rem == CW'(1)) ? DRAIN : RUN;
            DRAIN:   state_nx = CAPTURE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            op_q      <= HOLD_SEL;
            len_q     <= '0;
            rem       <= '0;
            sticky    <= 1'b0;
            acc_rst_n <= 1'b0;
            acc_sel   <= HOLD_SEL;
            acc_data1 <= '0;
            acc_data2 <= '0;
            done      <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
        end else begin
            // registered clear: low exactly while the FSM sits in CLEAR
            acc_rst_n <= state_nx != CLEAR;
            acc_sel   <= accept ? op_q : HOLD_SEL;
            done      <= state == CAPTURE;
            if (state == IDLE && bus.i_start) begin
                op_q  <= bus.i_op;
                len_q <= bus.i_len;
            end
            if (accept) begin
                acc_data1 <= bus.i_data1;
                acc_data2 <= bus.i_data2;
            end
            if (state == CLEAR)
                rem <= len_q;
            else if (accept)
                rem <= rem - CW'(1);
            // carry of each update shows one cycle after it, so RUN/DRAIN plus CAPTURE see them all
            if (state == CLEAR)
                sticky <= 1'b0;
            else if (state == RUN || state == DRAIN)
                sticky <= sticky | bus.i_acc_carry;
            if (state == CAPTURE) begin
                result <= bus.i_acc_data;
                ovf    <= sticky | bus.i_acc_carry;
            end
        end
    end

    assign bus.o_ready     = state == RUN;
    assign bus.o_busy      = state != IDLE;
    assign bus.o_acc_rst_n = acc_rst_n;
    assign bus.o_acc_sel   = acc_sel;
    assign bus.o_acc_data1 = acc_data1;
    assign bus.o_acc_data2 = acc_data2;
    assign bus.o_done      = done;
    assign bus.o_result    = result;
    assign bus.o_ovf       = ovf;
endmodule

// File: tb/tb_uns_acc_ctrl.sv
// tb_uns_acc_ctrl: randomized self-checking bench for uns_acc_ctrl with an accumulator model
module tb_uns_acc_ctrl;
    localparam logic [1:0] HOLD = 2'b11;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [2:0] bd1 [16];
    logic [2:0] bd2 [16];
    logic [6:0] add;

    uns_acc_ctrl_if #(.DW(3), .AW(6), .CW(4)) bus ();

    uns_acc_ctrl #(.DW(3), .AW(6), .CW(4), .HOLD_SEL(HOLD)) dut (
        .clk   (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // accumulator: 00 +d1, 01 +d2, 10 +d1+d2, 11 hold; 6-bit wrap with carry-out
    always_comb
        add = bus.o_acc_sel == 2'd0 ? 7'(bus.o_acc_data1) :
              bus.o_acc_sel == 2'd1 ? 7'(bus.o_acc_data2) :
              bus.o_acc_sel == 2'd2 ? 7'(bus.o_acc_data1) + 7'(bus.o_acc_data2) : 7'd0;

    always_ff @(posedge clk or negedge bus.o_acc_rst_n) begin
        if (!bus.o_acc_rst_n) begin
            bus.i_acc_data  <= '0;
            bus.i_acc_carry <= 1'b0;
        end else begin
            {bus.i_acc_carry, bus.i_acc_data} <= {1'b0, bus.i_acc_data} + add;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic [1:0] op, input int len, output logic [5:0] r, output logic o);
        int acc = 0;
        o = 1'b0;
        for (int i = 0; i < len; i++) begin
            acc += op == 2'd0 ? int'(bd1[i]) : op == 2'd1 ? int'(bd2[i]) :
                   op == 2'd2 ? int'(bd1[i]) + int'(bd2[i]) : 0;
            if (acc >= 64) begin
                acc -= 64;
                o = 1'b1;
            end
        end
        r = 6'(acc);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 16; i++) begin
            bd1[i] = 3'($urandom_range(0, 7));
            bd2[i] = 3'($urandom_range(0, 7));
        end
    endtask

    // called at a negedge with the controller idle; returns at the negedge where o_done is high
    task automatic do_job(input logic [1:0] op, input int len, input int gap, input bit stray);
        logic [5:0] exp_res;
        logic       exp_ovf;
        int         g;
        model(op, len, exp_res, exp_ovf);
        bus.i_start = 1'b1;
        bus.i_op    = op;
        bus.i_len   = 4'(len);
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_op    = 2'($urandom_range(0, 3));
        bus.i_len   = 4'($urandom_range(0, 15));
        check("clr_rst_n", bus.o_acc_rst_n, 0);
        check("clr_busy", bus.o_busy, 1);
        check("clr_ready", bus.o_ready, 0);
        @(negedge clk);
        check("post_clr_rst_n", bus.o_acc_rst_n, 1);
        for (int i = 0; i < len; i++) begin
            g = gap == 1 ? (i > 0 ? 2 : 0) : gap == 2 ? int'($urandom_range(0, 2)) : 0;
            repeat (g) begin
                bus.i_valid = 1'b0;
                bus.i_start = stray;
                @(negedge clk);
                bus.i_start = 1'b0;
                check("gap_sel", bus.o_acc_sel, HOLD);
            end
            bus.i_valid = 1'b1;
            bus.i_data1 = bd1[i];
            bus.i_data2 = bd2[i];
            check("ready", bus.o_ready, 1);
            @(negedge clk);
            check("beat_sel", bus.o_acc_sel, op);
            check("beat_d1", bus.o_acc_data1, bd1[i]);
            check("beat_d2", bus.o_acc_data2, bd2[i]);
        end
        bus.i_valid = 1'b1;
        bus.i_data1 = 3'($urandom_range(0, 7));
        check("drain_ready", bus.o_ready, 0);
        check("drain_done", bus.o_done, 0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        check("cap_sel", bus.o_acc_sel, HOLD);
        check("cap_done", bus.o_done, 0);
        check("cap_busy", bus.o_busy, 1);
        @(negedge clk);
        check("done", bus.o_done, 1);
        check("done_busy", bus.o_busy, 0);
        check("result", bus.o_result, exp_res);
        check("ovf", bus.o_ovf, exp_ovf);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        check("idle_busy", bus.o_busy, 0);
        check("idle_done", bus.o_done, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, bus.o_busy, 0);
        check({tag, "_ready"}, bus.o_ready, 0);
        check({tag, "_done"}, bus.o_done, 0);
        check({tag, "_sel"}, bus.o_acc_sel, HOLD);
        check({tag, "_rst_n"}, bus.o_acc_rst_n, 0);
        check({tag, "_d1"}, bus.o_acc_data1, 0);
        check({tag, "_d2"}, bus.o_acc_data2, 0);
        check({tag, "_result"}, bus.o_result, 0);
        check({tag, "_ovf"}, bus.o_ovf, 0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_op    = 2'd0;
        bus.i_len   = '0;
        bus.i_valid = 1'b0;
        bus.i_data1 = '0;
        bus.i_data2 = '0;
        repeat (5) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);
        check("rel_rst_n", bus.o_acc_rst_n, 1);
        check("rel_busy", bus.o_busy, 0);

        bd1[0] = 3'd1; bd2[0] = 3'd2;
        bd1[1] = 3'd3; bd2[1] = 3'd4;
        bd1[2] = 3'd7; bd2[2] = 3'd7;
        do_job(2'd2, 3, 0, 1'b0);
        check("job24_result", bus.o_result, 24);
        idle_cycle();
        do_job(2'd2, 3, 1, 1'b0);
        idle_cycle();

        for (int i = 0; i < 5; i++) begin
            bd1[i] = 3'd7;
            bd2[i] = 3'd7;
        end
        do_job(2'd2, 5, 0, 1'b0);
        check("wrap_result", bus.o_result, 6);
        check("wrap_ovf", bus.o_ovf, 1);
        bd1[0] = 3'd5; bd2[0] = 3'd0;
        do_job(2'd0, 1, 0, 1'b0);
        idle_cycle();

        do_job(2'd1, 0, 0, 1'b0);
        idle_cycle();
        fill_rand();
        do_job(2'd2, 4, 1, 1'b1);
        idle_cycle();

        for (int i = 0; i < 15; i++) begin
            bd1[i] = 3'd7;
            bd2[i] = 3'd7;
        end
        do_job(2'd2, 15, 0, 1'b0);
        idle_cycle();

        fill_rand();
        bus.i_start = 1'b1;
        bus.i_op    = 2'd2;
        bus.i_len   = 4'd4;
        @(negedge clk);
        bus.i_start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bus.i_valid = 1'b1;
            bus.i_data1 = bd1[i];
            bus.i_data2 = bd2[i];
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
        check("mid_busy", bus.o_busy, 1);
        #2 rst = 1'b1;
        #1 check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bd1[0] = 3'd0; bd2[0] = 3'd3;
        bd1[1] = 3'd0; bd2[1] = 3'd4;
        do_job(2'd1, 2, 0, 1'b0);
        check("post_rst_result", bus.o_result, 7);

        for (int j = 0; j < 40; j++) begin
            fill_rand();
            do_job(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1)
                idle_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
